// File: rtl/ball_motion.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ball_motion                                                     |
// | Brief    : Ball kinematics for the brick-breaker playfield. Rides on the   |
// |            paddle while idle, then moves 1 px per axis per tick with wall, |
// |            paddle and brick reflection, and reports a miss at the bottom.  |
// | Options  : BALL_SPEEDUP_EN - every 8th paddle hit halves the tick period  |
// |            (up to two levels); cleared on miss and reset.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ball_motion #(
  parameter int X_MIN     = 134,
  parameter int X_MAX     = 506,
  parameter int Y_MIN     = 40,
  parameter int Y_MAX     = 480,
  parameter int PADDLE_Y  = 440,
  parameter int PADDLE_W  = 62,
  parameter int BALL_SIZE = 8,
  parameter int TICK_DIV  = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] paddle_x,
  input  logic       brick_hit,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic       dx_neg,
  output logic       dy_neg,
  output logic       paddle_hit,
  output logic       miss
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  // All geometry compares are done on 10-bit zero-extended values so sums never wrap.
  localparam logic [9:0] C_XMIN  = 10'(X_MIN);
  localparam logic [9:0] C_XMAX  = 10'(X_MAX);
  localparam logic [9:0] C_YMIN  = 10'(Y_MIN);
  localparam logic [9:0] C_YMAX  = 10'(Y_MAX);
  localparam logic [9:0] C_PY    = 10'(PADDLE_Y);
  localparam logic [9:0] C_PW    = 10'(PADDLE_W);
  localparam logic [9:0] C_BS    = 10'(BALL_SIZE);
  localparam logic [9:0] C_XOFF  = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [8:0] C_RESTY = 9'(PADDLE_Y - BALL_SIZE);
  // Reset x is the rest position over the paddle controller's reset x of 290.
  localparam logic [8:0] C_RSTX  = 9'(290 + PADDLE_W / 2 - BALL_SIZE / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_MISS = 2'd2
  } state_t;

  state_t        r_state, n_state;
  logic [CW-1:0] r_cnt, n_cnt;
  logic          r_pend, n_pend;
  logic [8:0]    n_x, n_y;
  logic          n_dxn, n_dyn, n_phit, n_miss;
  logic [CW-1:0] w_last;
  logic          w_tick;
  logic [9:0]    w_x, w_y, w_px, w_rest_x;

  assign w_x      = {1'b0, ball_x};
  assign w_y      = {1'b0, ball_y};
  assign w_px     = {1'b0, paddle_x};
  assign w_rest_x = w_px + C_XOFF;

`ifdef BALL_SPEEDUP_EN
  logic [2:0]  r_hits;
  logic [1:0]  r_level;
  logic [31:0] w_period;

  assign w_period = 32'(TICK_DIV) >> r_level;
  assign w_last   = CW'(w_period - 32'd1);

  // Count paddle hits; every 8th raises the speed level (saturating at 2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hits  <= 3'd0;
      r_level <= 2'd0;
    end else if (n_state == S_MISS) begin
      r_hits  <= 3'd0;
      r_level <= 2'd0;
    end else if (n_phit) begin
      r_hits <= r_hits + 3'd1;
      if (r_hits == 3'd7 && r_level != 2'd2) begin
        r_level <= r_level + 2'd1;
      end
    end
  end
`else
  assign w_last = CW'(TICK_DIV - 1);
`endif

  assign w_tick = (r_state == S_MOVE) && start && (r_cnt == w_last);

  // Next-state, next-position and pulse outputs.
  always_comb begin
    n_state = r_state;
    n_cnt   = r_cnt;
    n_pend  = r_pend;
    n_x     = ball_x;
    n_y     = ball_y;
    n_dxn   = dx_neg;
    n_dyn   = dy_neg;
    n_phit  = 1'b0;
    n_miss  = 1'b0;
    case (r_state)
      S_IDLE: begin
        n_x    = w_rest_x[8:0];
        n_y    = C_RESTY;
        n_pend = 1'b0;
        if (start) begin
          n_state = S_MOVE;
          n_dxn   = 1'b0;
          n_dyn   = 1'b1;
          n_cnt   = '0;
        end
      end
      S_MOVE: begin
        // A pulse landing on the tick cycle itself is kept for the next tick.
        if (brick_hit) begin
          n_pend = 1'b1;
        end else if (w_tick) begin
          n_pend = 1'b0;
        end
        if (start) begin
          if (w_tick) begin
            n_cnt = '0;
            if (!dy_neg && (w_y + C_BS >= C_YMAX)) begin
              n_state = S_MISS;
              n_miss  = 1'b1;
            end else begin
              if (!dy_neg && (w_y + C_BS == C_PY) &&
                  (w_x + C_BS > w_px) && (w_x < w_px + C_PW)) begin
                n_dyn  = 1'b1;
                n_y    = ball_y - 9'd1;
                n_phit = 1'b1;
              end else if (dy_neg && (w_y <= C_YMIN)) begin
                n_dyn = 1'b0;
                n_y   = ball_y + 9'd1;
              end else if (r_pend) begin
                n_dyn = ~dy_neg;
                n_y   = dy_neg ? ball_y + 9'd1 : ball_y - 9'd1;
              end else begin
                n_y   = dy_neg ? ball_y - 9'd1 : ball_y + 9'd1;
              end
              if (dx_neg && (w_x <= C_XMIN)) begin
                n_dxn = 1'b0;
                n_x   = ball_x + 9'd1;
              end else if (!dx_neg && (w_x + C_BS >= C_XMAX)) begin
                n_dxn = 1'b1;
                n_x   = ball_x - 9'd1;
              end else begin
                n_x   = dx_neg ? ball_x - 9'd1 : ball_x + 9'd1;
              end
            end
          end else begin
            n_cnt = r_cnt + CW'(1);
          end
        end
      end
      S_MISS: begin
        // Put the ball straight back on the paddle so IDLE starts at rest.
        n_state = S_IDLE;
        n_x     = w_rest_x[8:0];
        n_y     = C_RESTY;
        n_dxn   = 1'b0;
        n_dyn   = 1'b1;
        n_cnt   = '0;
        n_pend  = 1'b0;
      end
      default: begin
        n_state = S_IDLE;
      end
    endcase
  end

  // State, position and pulse registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      ball_x     <= C_RSTX;
      ball_y     <= C_RESTY;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b1;
      paddle_hit <= 1'b0;
      miss       <= 1'b0;
    end else begin
      r_state    <= n_state;
      r_cnt      <= n_cnt;
      r_pend     <= n_pend;
      ball_x     <= n_x;
      ball_y     <= n_y;
      dx_neg     <= n_dxn;
      dy_neg     <= n_dyn;
      paddle_hit <= n_phit;
      miss       <= n_miss;
    end
  end

endmodule
`default_nettype wire
